add8u_error_meter: RTL and testbench

//  Sequential stimulus/checker for 8-bit unsigned approximate adders (add8u_* family).

---
 rtl/add8u_eval_pkg.sv | 28 ++
 rtl/add8u_eval_delay.sv | 48 ++++
 rtl/add8u_error_meter.sv | 190 +++++++++++++++++++
 tb/tb_add8u_error_meter.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add8u_eval_pkg.sv
// Shared types and constants for the add8u error meter.
//   state_e   : sweep controller states
//   W         : operand width the result widths below are sized for
//   SWEEP_LEN : number of operand pairs in one exhaustive sweep
//   *_W       : result widths, large enough for a full sweep without overflow
//   abs_diff  : |x - y| on sum-width values
package add8u_eval_pkg;

  localparam int unsigned W         = 8;
  localparam int unsigned SWEEP_LEN = 1 << (2 * W);
  localparam int unsigned ERR_W     = 9;
  localparam int unsigned SAE_W     = 25;
  localparam int unsigned SSE_W     = 34;
  localparam int unsigned CNT_W     = 17;

  typedef enum logic [1:0] {
    StIdle,
    StSweep,
    StDrain,
    StDone
  } state_e;

  function automatic logic [ERR_W-1:0] abs_diff(input logic [ERR_W-1:0] x,
                                                input logic [ERR_W-1:0] y);
    return (x >= y) ? (x - y) : (y - x);
  endfunction

endpackage

// File: rtl/add8u_eval_delay.sv
// Fixed-latency shift register that carries {valid, data} alongside the adder under test,
// so the operands reach the error stage in the same cycle as the adder's sum.
//   clk, rst  : clock, asynchronous active-high reset
//   in_valid  : valid bit entering the line
//   in_data   : payload entering the line
//   out_valid : in_valid delayed by Depth cycles
//   out_data  : in_data delayed by Depth cycles
// Depth = 0 is a plain wire.
module add8u_eval_delay #(
  parameter int unsigned Depth = 0,
  parameter int unsigned DataW = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [DataW-1:0] in_data,
  output logic             out_valid,
  output logic [DataW-1:0] out_data
);

  if (Depth == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign out_valid      = in_valid;
    assign out_data       = in_data;
  end else begin : g_pipe
    logic [Depth-1:0] valid_q;
    logic [DataW-1:0] data_q [Depth];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= '0;
        for (int i = 0; i < int'(Depth); i++) data_q[i] <= '0;
      end else begin
        valid_q[0] <= in_valid;
        data_q[0]  <= in_data;
        for (int i = 1; i < int'(Depth); i++) begin
          valid_q[i] <= valid_q[i-1];
          data_q[i]  <= data_q[i-1];
        end
      end
    end

    assign out_valid = valid_q[Depth-1];
    assign out_data  = data_q[Depth-1];
  end

endmodule

// File: rtl/add8u_error_meter.sv
// Exhaustive error meter for 8-bit unsigned approximate adders.
// Drives every (A, B) pair into the adder, one per cycle, compares its sum with A+B and
// accumulates error-probability count, worst-case error (with its first operands),
// sum of |e| and sum of e^2.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : begin a sweep (honoured only when idle or done)
//   busy       : sweep or drain in progress
//   done       : one-cycle pulse; results are final and held afterwards
//   dut_a/b    : registered operands to the adder
//   dut_o      : adder sum, DUT_LAT cycles after dut_a/dut_b
//   err_count  : number of pairs with a wrong sum
//   wce        : maximum |error|; wce_a/wce_b are the first pair that reached it
//   sae, sse   : sum of |error| and sum of error^2
module add8u_error_meter import add8u_eval_pkg::*; #(
  parameter int unsigned W       = 8,
  parameter int unsigned DUT_LAT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     dut_a,
  output logic [W-1:0]     dut_b,
  input  logic [W:0]       dut_o,
  output logic [CNT_W-1:0] err_count,
  output logic [ERR_W-1:0] wce,
  output logic [W-1:0]     wce_a,
  output logic [W-1:0]     wce_b,
  output logic [SAE_W-1:0] sae,
  output logic [SSE_W-1:0] sse
);

  // Drain covers the DUT latency plus the error and accumulate stages.
  localparam int unsigned DrainLast = DUT_LAT + 1;

  state_e         state_q, state_d;
  logic [2*W-1:0] cnt_q;
  logic [2:0]     drain_q;
  logic           issue, clear, done_d;
  logic           done_q, issue_valid_q;
  logic [W-1:0]   dut_a_q, dut_b_q;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StSweep;
      StSweep: if (cnt_q == '1) state_d = StDrain;
      StDrain: if (drain_q == 3'(DrainLast)) state_d = StDone;
      StDone:  if (start) state_d = StSweep;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy  = 1'b0;
    issue = 1'b0;
    clear = 1'b0;
    case (state_q)
      StIdle, StDone: clear = start;
      StSweep: begin
        busy  = 1'b1;
        issue = 1'b1;
      end
      StDrain: busy = 1'b1;
      default: ;
    endcase
    done_d = (state_q == StDrain) && (state_d == StDone);
  end

  // ---------------------------------------------------------------- sweep counter / operands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      drain_q       <= '0;
      dut_a_q       <= '0;
      dut_b_q       <= '0;
      issue_valid_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q        <= done_d;
      issue_valid_q <= issue;
      if (clear) begin
        cnt_q <= '0;
      end else if (issue) begin
        {dut_b_q, dut_a_q} <= cnt_q;
        cnt_q              <= cnt_q + 1'b1;
      end
      if (state_q == StDrain) drain_q <= drain_q + 1'b1;
      else                    drain_q <= '0;
    end
  end

  assign dut_a = dut_a_q;
  assign dut_b = dut_b_q;
  assign done  = done_q;

  // ---------------------------------------------------------------- operand delay line
  logic           d_valid;
  logic [2*W-1:0] d_data;
  logic [W-1:0]   d_a, d_b;

  add8u_eval_delay #(
    .Depth (DUT_LAT),
    .DataW (2 * W)
  ) u_delay (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (issue_valid_q),
    .in_data   ({dut_a_q, dut_b_q}),
    .out_valid (d_valid),
    .out_data  (d_data)
  );

  assign {d_a, d_b} = d_data;

  // ---------------------------------------------------------------- error stage
  logic [ERR_W-1:0] exact;
  logic [ERR_W-1:0] e_q;
  logic             e_valid_q;
  logic [W-1:0]     e_a_q, e_b_q;

  assign exact = {1'b0, d_a} + {1'b0, d_b};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_valid_q <= 1'b0;
      e_q       <= '0;
      e_a_q     <= '0;
      e_b_q     <= '0;
    end else begin
      e_valid_q <= d_valid;
      e_q       <= abs_diff(dut_o, exact);
      e_a_q     <= d_a;
      e_b_q     <= d_b;
    end
  end

  // ---------------------------------------------------------------- accumulators
  logic [2*ERR_W-1:0] e_sq;
  logic [CNT_W-1:0]   err_q;
  logic [ERR_W-1:0]   wce_q;
  logic [W-1:0]       wce_a_q, wce_b_q;
  logic [SAE_W-1:0]   sae_q;
  logic [SSE_W-1:0]   sse_q;

  assign e_sq = {{ERR_W{1'b0}}, e_q} * {{ERR_W{1'b0}}, e_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q   <= '0;
      wce_q   <= '0;
      wce_a_q <= '0;
      wce_b_q <= '0;
      sae_q   <= '0;
      sse_q   <= '0;
    end else if (clear) begin
      err_q   <= '0;
      wce_q   <= '0;
      wce_a_q <= '0;
      wce_b_q <= '0;
      sae_q   <= '0;
      sse_q   <= '0;
    end else if (e_valid_q) begin
      sae_q <= sae_q + SAE_W'(e_q);
      sse_q <= sse_q + SSE_W'(e_sq);
      if (e_q != '0) err_q <= err_q + 1'b1;
      // Strict compare keeps the earliest pair in sweep order.
      if (e_q > wce_q) begin
        wce_q   <= e_q;
        wce_a_q <= e_a_q;
        wce_b_q <= e_b_q;
      end
    end
  end

  assign err_count = err_q;
  assign wce       = wce_q;
  assign wce_a     = wce_a_q;
  assign wce_b     = wce_b_q;
  assign sae       = sae_q;
  assign sse       = sse_q;

endmodule

// File: tb/tb_add8u_error_meter.sv
module tb_add8u_error_meter;

  localparam int NI    = 5;
  localparam int SWEEP = 65536;

  // Instance roles: 0 exact, 1 LSB-OR (start pulses mid-sweep and restart from done),
  // 2 constant zero, 3 exact registered with 2-cycle latency, 4 LSB-OR reset mid-sweep.
  function automatic int kind_of(int i);
    case (i)
      1, 4:    return 1;
      2:       return 2;
      default: return 0;
    endcase
  endfunction

  function automatic int lat_of(int i);
    return (i == 3) ? 2 : 0;
  endfunction

  function automatic logic [8:0] model_o(int kind, logic [7:0] a, logic [7:0] b);
    logic [7:0] hi;
    hi = {1'b0, a[7:1]} + {1'b0, b[7:1]};
    if (kind == 0) return {1'b0, a} + {1'b0, b};
    if (kind == 1) return {hi, a[0] | b[0]};
    return 9'd0;
  endfunction

  typedef struct {
    int     inst;
    int     done_cyc;
    int     err_count;
    int     wce;
    int     wce_a;
    int     wce_b;
    longint sae;
    longint sse;
  } exp_t;

  function automatic exp_t model_run(int kind, int npairs);
    exp_t       r;
    logic [7:0] a, b;
    int         exact, o, e;
    r = '{default: 0};
    for (int k = 0; k < npairs; k++) begin
      a     = k[7:0];
      b     = k[15:8];
      exact = int'(a) + int'(b);
      o     = int'(model_o(kind, a, b));
      e     = (o > exact) ? o - exact : exact - o;
      if (e != 0) r.err_count++;
      r.sae += e;
      r.sse += longint'(e) * e;
      if (e > r.wce) begin
        r.wce   = e;
        r.wce_a = int'(a);
        r.wce_b = int'(b);
      end
    end
    return r;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic        rst_v     [NI];
  logic        start     [NI];
  logic        busy      [NI];
  logic        done      [NI];
  logic [7:0]  dut_a     [NI];
  logic [7:0]  dut_b     [NI];
  logic [8:0]  dut_o     [NI];
  logic [16:0] err_count [NI];
  logic [8:0]  wce       [NI];
  logic [7:0]  wce_a     [NI];
  logic [7:0]  wce_b     [NI];
  logic [24:0] sae       [NI];
  logic [33:0] sse       [NI];

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int Kind = kind_of(g);
    localparam int Lat  = lat_of(g);
    logic [8:0] o_now, o_r1, o_r2;
    assign o_now = model_o(Kind, dut_a[g], dut_b[g]);
    always @(posedge clk) begin
      o_r1 <= o_now;
      o_r2 <= o_r1;
    end
    assign dut_o[g] = (Lat == 2) ? o_r2 : o_now;

    add8u_error_meter #(
      .W       (8),
      .DUT_LAT (Lat)
    ) u_meter (
      .clk       (clk),
      .rst       (rst_v[g]),
      .start     (start[g]),
      .busy      (busy[g]),
      .done      (done[g]),
      .dut_a     (dut_a[g]),
      .dut_b     (dut_b[g]),
      .dut_o     (dut_o[g]),
      .err_count (err_count[g]),
      .wce       (wce[g]),
      .wce_a     (wce_a[g]),
      .wce_b     (wce_b[g]),
      .sae       (sae[g]),
      .sse       (sse[g])
    );
  end

  exp_t sb_q[$];
  exp_t kind_exp [3];
  int   launch_cyc;

  task automatic wait_until(int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < NI; i++) begin
      rst_v[i] = 1'b1;
      start[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (busy[i] !== 1'b0 || done[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_busy_done[%0d]: got %b%b want 00", i, busy[i], done[i]);
      end
      checks++;
      if (dut_a[i] !== 8'd0 || dut_b[i] !== 8'd0) begin
        errors++;
        $display("FAIL reset_operands[%0d]: got %0d,%0d want 0,0", i, dut_a[i], dut_b[i]);
      end
      checks++;
      if (err_count[i] !== 17'd0 || wce[i] !== 9'd0 || wce_a[i] !== 8'd0 || wce_b[i] !== 8'd0) begin
        errors++;
        $display("FAIL reset_err_wce[%0d]: got %0d/%0d/%0d/%0d want 0/0/0/0", i,
                 err_count[i], wce[i], wce_a[i], wce_b[i]);
      end
      checks++;
      if (sae[i] !== 25'd0 || sse[i] !== 34'd0) begin
        errors++;
        $display("FAIL reset_sums[%0d]: got %0d/%0d want 0/0", i, sae[i], sse[i]);
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) rst_v[i] = 1'b0;
  endtask

  task automatic test_launch();
    exp_t e;
    for (int k = 0; k < 3; k++) kind_exp[k] = model_run(k, SWEEP);
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) start[i] = 1'b1;
    launch_cyc = cyc + 1;
    for (int i = 0; i < 4; i++) begin
      e          = kind_exp[kind_of(i)];
      e.inst     = i;
      e.done_cyc = launch_cyc + SWEEP + lat_of(i) + 2;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) start[i] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (busy[i] !== 1'b1 || done[i] !== 1'b0) begin
        errors++;
        $display("FAIL launch_busy[%0d]: got busy=%b done=%b want busy=1 done=0", i, busy[i], done[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    wait_until(launch_cyc + 1000);
    rst_v[4] = 1'b1;
    #1;
    checks++;
    if (busy[4] !== 1'b0 || done[4] !== 1'b0) begin
      errors++;
      $display("FAIL midrst_busy: got busy=%b done=%b want 0 0", busy[4], done[4]);
    end
    checks++;
    if (err_count[4] !== 17'd0 || wce[4] !== 9'd0 || sae[4] !== 25'd0 || sse[4] !== 34'd0) begin
      errors++;
      $display("FAIL midrst_results: got %0d/%0d/%0d/%0d want 0/0/0/0",
               err_count[4], wce[4], sae[4], sse[4]);
    end
    checks++;
    if (dut_a[4] !== 8'd0 || dut_b[4] !== 8'd0) begin
      errors++;
      $display("FAIL midrst_operands: got %0d,%0d want 0,0", dut_a[4], dut_b[4]);
    end
    @(posedge clk);
    #1;
    rst_v[4] = 1'b0;
    @(posedge clk);
    #1;
    start[4]   = 1'b1;
    e          = kind_exp[1];
    e.inst     = 4;
    e.done_cyc = cyc + 1 + SWEEP + 2;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    start[4] = 1'b0;
    @(negedge clk);
    checks++;
    if (busy[4] !== 1'b1) begin
      errors++;
      $display("FAIL midrst_restart_busy: got %b want 1", busy[4]);
    end
  endtask

  task automatic test_ignore_start();
    int targets [2];
    targets[0] = launch_cyc + 2000;
    targets[1] = launch_cyc + 30000;
    for (int t = 0; t < 2; t++) begin
      wait_until(targets[t]);
      start[1] = 1'b1;
      @(posedge clk);
      #1;
      start[1] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (busy[1] !== 1'b1) begin
        errors++;
        $display("FAIL ignore_busy: got %b want 1", busy[1]);
      end
      checks++;
      if ({dut_b[1], dut_a[1]} !== 16'(cyc - launch_cyc - 1)) begin
        errors++;
        $display("FAIL ignore_pair: got %0d want %0d", {dut_b[1], dut_a[1]}, cyc - launch_cyc - 1);
      end
    end
  endtask

  task automatic test_sweep_results();
    exp_t e;
    int   idx;
    int   limit;
    limit = launch_cyc + SWEEP + 3000;
    while (sb_q.size() > 0 && cyc < limit) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (done[i] === 1'b1) begin
          idx = -1;
          for (int j = sb_q.size() - 1; j >= 0; j--) if (sb_q[j].inst == i) idx = j;
          checks++;
          if (idx < 0) begin
            errors++;
            $display("FAIL unexpected_done[%0d]: got done=1 at cycle %0d want no pulse", i, cyc);
          end else begin
            e = sb_q[idx];
            sb_q.delete(idx);
            if (cyc !== e.done_cyc) begin
              errors++;
              $display("FAIL done_cycle[%0d]: got %0d want %0d", i, cyc, e.done_cyc);
            end
            checks++;
            if (busy[i] !== 1'b0) begin
              errors++;
              $display("FAIL done_busy[%0d]: got %b want 0", i, busy[i]);
            end
            checks++;
            if (err_count[i] !== 17'(e.err_count)) begin
              errors++;
              $display("FAIL err_count[%0d]: got %0d want %0d", i, err_count[i], e.err_count);
            end
            checks++;
            if (wce[i] !== 9'(e.wce) || wce_a[i] !== 8'(e.wce_a) || wce_b[i] !== 8'(e.wce_b)) begin
              errors++;
              $display("FAIL wce[%0d]: got %0d@(%0d,%0d) want %0d@(%0d,%0d)", i, wce[i], wce_a[i],
                       wce_b[i], e.wce, e.wce_a, e.wce_b);
            end
            checks++;
            if (sae[i] !== 25'(e.sae)) begin
              errors++;
              $display("FAIL sae[%0d]: got %0d want %0d", i, sae[i], e.sae);
            end
            checks++;
            if (sse[i] !== 34'(e.sse)) begin
              errors++;
              $display("FAIL sse[%0d]: got %0d want %0d", i, sse[i], e.sse);
            end
          end
        end
      end
    end
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      errors++;
      $display("FAIL done_timeout[%0d]: got no done by cycle %0d want done at %0d", e.inst, cyc,
               e.done_cyc);
    end
  endtask

  task automatic test_done_restart();
    exp_t p;
    int   s;
    @(negedge clk);
    checks++;
    if (done[1] !== 1'b0 || busy[1] !== 1'b0) begin
      errors++;
      $display("FAIL hold_flags: got done=%b busy=%b want 0 0", done[1], busy[1]);
    end
    checks++;
    if (err_count[1] !== 17'(kind_exp[1].err_count) || sae[1] !== 25'(kind_exp[1].sae)) begin
      errors++;
      $display("FAIL hold_results: got %0d/%0d want %0d/%0d", err_count[1], sae[1],
               kind_exp[1].err_count, kind_exp[1].sae);
    end
    @(posedge clk);
    #1;
    start[1] = 1'b1;
    s        = cyc + 1;
    @(posedge clk);
    #1;
    start[1] = 1'b0;
    @(negedge clk);
    checks++;
    if (busy[1] !== 1'b1) begin
      errors++;
      $display("FAIL restart_busy: got %b want 1", busy[1]);
    end
    checks++;
    if (err_count[1] !== 17'd0 || wce[1] !== 9'd0 || sae[1] !== 25'd0 || sse[1] !== 34'd0) begin
      errors++;
      $display("FAIL restart_clear: got %0d/%0d/%0d/%0d want 0/0/0/0",
               err_count[1], wce[1], sae[1], sse[1]);
    end
    wait_until(s + 300);
    @(negedge clk);
    p = model_run(1, cyc - s - 2);
    checks++;
    if (err_count[1] !== 17'(p.err_count) || sae[1] !== 25'(p.sae) || sse[1] !== 34'(p.sse)) begin
      errors++;
      $display("FAIL restart_partial: got %0d/%0d/%0d want %0d/%0d/%0d", err_count[1], sae[1],
               sse[1], p.err_count, p.sae, p.sse);
    end
    checks++;
    if (wce[1] !== 9'(p.wce) || wce_a[1] !== 8'(p.wce_a) || wce_b[1] !== 8'(p.wce_b)) begin
      errors++;
      $display("FAIL restart_wce: got %0d@(%0d,%0d) want %0d@(%0d,%0d)", wce[1], wce_a[1],
               wce_b[1], p.wce, p.wce_a, p.wce_b);
    end
  endtask

  initial begin
    test_reset();
    test_launch();
    test_mid_reset();
    test_ignore_start();
    test_sweep_results();
    test_done_restart();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
